// File: rtl/sap1_control_seq.sv
// sap1_control_seq: SAP-1 hardwired control sequencer (T1..T6 ring counter, opcode decode, halt latch).
module sap1_control_seq #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic [3:0] OPCODE,
    output logic [5:0] T_STATE,
    output logic       CP,
    output logic       EP,
    output logic       LM,
    output logic       CE,
    output logic       LI,
    output logic       EI,
    output logic       LA,
    output logic       EA,
    output logic       SU,
    output logic       EU,
    output logic       LB,
    output logic       LO,
    output logic       HLT
);
    logic halted;
    logic is_lda, is_add, is_sub, is_out, is_mem, run;

    // Halting freezes the ring at T4; only CLR_N releases it.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            T_STATE <= 6'b000001;
            halted  <= 1'b0;
        end else if (!halted) begin
            if (T_STATE[3] && OPCODE == OP_HLT)
                halted <= 1'b1;
            else
                T_STATE <= {T_STATE[4:0], T_STATE[5]};
        end
    end

    always_comb begin
        is_lda = OPCODE == OP_LDA;
        is_add = OPCODE == OP_ADD;
        is_sub = OPCODE == OP_SUB;
        is_out = OPCODE == OP_OUT;
        is_mem = is_lda | is_add | is_sub;
        run    = !halted;
        EP     = run & T_STATE[0];
        CP     = run & T_STATE[1];
        LI     = run & T_STATE[2];
        LM     = run & (T_STATE[0] | (T_STATE[3] & is_mem));
        CE     = run & (T_STATE[2] | (T_STATE[4] & is_mem));
        EI     = run & T_STATE[3] & is_mem;
        EA     = run & T_STATE[3] & is_out;
        LO     = run & T_STATE[3] & is_out;
        LB     = run & T_STATE[4] & (is_add | is_sub);
        LA     = run & ((T_STATE[4] & is_lda) | (T_STATE[5] & (is_add | is_sub)));
        EU     = run & T_STATE[5] & (is_add | is_sub);
        SU     = run & T_STATE[5] & is_sub;
        HLT    = halted;
    end
endmodule

// File: tb/tb_sap1_control_seq.sv
// tb_sap1_control_seq: table-driven check of the SAP-1 control sequencer plus reset/halt corner sequences.
module tb_sap1_control_seq;
    logic       CLK = 1'b0;
    logic       CLR_N;
    logic [3:0] OPCODE;
    logic [5:0] T_STATE;
    logic       CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HLT;
    logic [11:0] ctl;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  ts;
        logic [11:0] ctl;
        logic        hlt;
    } vec_t;
    vec_t vecs[$];

    // Bit order {CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}
    localparam logic [11:0] C_0    = 12'b0000_0000_0000;
    localparam logic [11:0] C_T1   = 12'b0110_0000_0000;
    localparam logic [11:0] C_T2   = 12'b1000_0000_0000;
    localparam logic [11:0] C_T3   = 12'b0001_1000_0000;
    localparam logic [11:0] C_ADDR = 12'b0010_0100_0000;
    localparam logic [11:0] C_OUT  = 12'b0000_0001_0001;
    localparam logic [11:0] C_LDA5 = 12'b0001_0010_0000;
    localparam logic [11:0] C_AB5  = 12'b0001_0000_0010;
    localparam logic [11:0] C_ADD6 = 12'b0000_0010_0100;
    localparam logic [11:0] C_SUB6 = 12'b0000_0010_1100;
    localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

    assign ctl = {CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO};

    sap1_control_seq dut (
        .CLK(CLK), .CLR_N(CLR_N), .OPCODE(OPCODE), .T_STATE(T_STATE),
        .CP(CP), .EP(EP), .LM(LM), .CE(CE), .LI(LI), .EI(EI), .LA(LA),
        .EA(EA), .SU(SU), .EU(EU), .LB(LB), .LO(LO), .HLT(HLT)
    );

    always #5 CLK = ~CLK;

    task automatic add(input logic [3:0] op, input logic [5:0] ts, input logic [11:0] c, input logic h);
        vecs.push_back('{op, ts, c, h});
    endtask

    task automatic chk(input string nm, input logic [5:0] ts, input logic [11:0] c, input logic h);
        int drv;
        drv = int'(EP) + int'(CE) + int'(EI) + int'(EA) + int'(EU);
        total++;
        if (T_STATE !== ts) begin
            bad++;
            $display("FAIL %s t_state got=%b want=%b", nm, T_STATE, ts);
        end
        total++;
        if (ctl !== c) begin
            bad++;
            $display("FAIL %s controls got=%b want=%b", nm, ctl, c);
        end
        total++;
        if (HLT !== h) begin
            bad++;
            $display("FAIL %s hlt got=%b want=%b", nm, HLT, h);
        end
        total++;
        if ($countones(T_STATE) != 1) begin
            bad++;
            $display("FAIL %s onehot got=%b want=one-hot", nm, T_STATE);
        end
        total++;
        if (drv > 1) begin
            bad++;
            $display("FAIL %s bus_drivers got=%0d want<=1", nm, drv);
        end
        total++;
        if ((LM | LI | LA | LB | LO) && drv == 0) begin
            bad++;
            $display("FAIL %s load_without_driver got=%b want=no load", nm, ctl);
        end
    endtask

    initial begin
        // ADD; T1-T3 entries carry unrelated opcodes to show they are ignored
        add(4'h3, T2, C_T2, 0); add(4'hF, T3, C_T3, 0); add(4'h1, T4, C_ADDR, 0);
        add(4'h1, T5, C_AB5, 0); add(4'h1, T6, C_ADD6, 0); add(4'hE, T1, C_T1, 0);
        // SUB
        add(4'h2, T2, C_T2, 0); add(4'h0, T3, C_T3, 0); add(4'h2, T4, C_ADDR, 0);
        add(4'h2, T5, C_AB5, 0); add(4'h2, T6, C_SUB6, 0); add(4'h0, T1, C_T1, 0);
        // LDA
        add(4'h0, T2, C_T2, 0); add(4'h0, T3, C_T3, 0); add(4'h0, T4, C_ADDR, 0);
        add(4'h0, T5, C_LDA5, 0); add(4'h0, T6, C_0, 0); add(4'hE, T1, C_T1, 0);
        // OUT
        add(4'hE, T2, C_T2, 0); add(4'hE, T3, C_T3, 0); add(4'hE, T4, C_OUT, 0);
        add(4'hE, T5, C_0, 0); add(4'hE, T6, C_0, 0); add(4'h7, T1, C_T1, 0);
        // NOP
        add(4'h7, T2, C_T2, 0); add(4'h7, T3, C_T3, 0); add(4'h7, T4, C_0, 0);
        add(4'h7, T5, C_0, 0); add(4'h7, T6, C_0, 0); add(4'hF, T1, C_T1, 0);
        // HLT, then 10 frozen clocks
        add(4'hF, T2, C_T2, 0); add(4'hF, T3, C_T3, 0); add(4'hF, T4, C_0, 0);
        for (int i = 0; i < 10; i++) add(4'hF, T4, C_0, 1);

        CLR_N = 1'b0;
        OPCODE = 4'h0;
        repeat (3) @(posedge CLK);
        #2 chk("reset_hold", T1, C_T1, 0);
        CLR_N = 1'b1;
        #1 chk("reset_release", T1, C_T1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge CLK);
            OPCODE = vecs[i].op;
            #2 chk($sformatf("vec%0d", i), vecs[i].ts, vecs[i].ctl, vecs[i].hlt);
        end

        // Only CLR_N leaves halt, and it acts without a clock edge
        #1 CLR_N = 1'b0;
        #1 chk("halt_clear", T1, C_T1, 0);
        @(negedge CLK);
        CLR_N = 1'b1;
        #1 chk("halt_clear_release", T1, C_T1, 0);

        // SUB to T5, then asynchronous reset mid-instruction
        OPCODE = 4'h2;
        @(posedge CLK); #2 chk("sub_t2", T2, C_T2, 0);
        @(posedge CLK); #2 chk("sub_t3", T3, C_T3, 0);
        @(posedge CLK); #2 chk("sub_t4", T4, C_ADDR, 0);
        @(posedge CLK); #2 chk("sub_t5", T5, C_AB5, 0);
        #1 CLR_N = 1'b0;
        #1 chk("mid_reset", T1, C_T1, 0);
        @(negedge CLK);
        CLR_N = 1'b1;
        OPCODE = 4'h7;
        #1 chk("mid_reset_release", T1, C_T1, 0);

        @(posedge CLK); #2 chk("nop_t2", T2, C_T2, 0);
        @(posedge CLK); #2 chk("nop_t3", T3, C_T3, 0);
        @(posedge CLK); #2 chk("nop_t4", T4, C_0, 0);
        @(posedge CLK); #2 chk("nop_t5", T5, C_0, 0);
        @(posedge CLK); #2 chk("nop_t6", T6, C_0, 0);
        @(posedge CLK); #2 chk("nop_wrap", T1, C_T1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sap1_control_seq.md
Name: sap1_control_seq

Overview:
- Hardwired control sequencer for the SAP-1 processor.
- Drives the control word for the datapath: PC, MAR, RAM, IR, accumulator, B register, ALU8_1 and output register.
- It is the initiator whose SU/EU outputs the ALU8_1 responds to; it also sequences every other bus driver and loader.
- Built from a 6-state ring counter (T1..T6) plus an opcode decoder and a halt latch.

Parameters:
- OP_LDA, 4'b0000, load accumulator opcode
- OP_ADD, 4'b0001, add opcode
- OP_SUB, 4'b0010, subtract opcode
- OP_OUT, 4'b1110, output opcode
- OP_HLT, 4'b1111, halt opcode

Ports:
- CLK  input  1  system clock; all state changes on the rising edge
- CLR_N  input  1  asynchronous active-low reset
- OPCODE  input  4  IR upper nibble; valid from T4 through T6
- T_STATE  output  6  one-hot ring state; bit0 = T1 … bit5 = T6
- CP  output  1  PC increment
- EP  output  1  PC drives bus
- LM  output  1  MAR load
- CE  output  1  RAM drives bus
- LI  output  1  IR load
- EI  output  1  IR operand nibble drives bus
- LA  output  1  accumulator load
- EA  output  1  accumulator drives bus
- SU  output  1  ALU subtract select
- EU  output  1  ALU drives bus
- LB  output  1  B register load
- LO  output  1  output register load
- HLT  output  1  processor halted; gates the system clock externally

Behaviour:
- All control outputs are active-high.
- Control outputs are combinational decodes of the T_STATE register, the halt flag and OPCODE. There are no other registers.
- Reset (CLR_N = 0, asynchronous):
  - T_STATE = 6'b000001 (T1); halt flag = 0.
  - Outputs during and immediately after reset: EP = 1, LM = 1, every other control output = 0, HLT = 0.
  - Reset asserted mid-instruction returns to T1 immediately, without waiting for a clock edge.
- Ring counter:
  - Each rising edge rotates T1→T2→…→T6→T1, unless halted.
  - Every instruction takes exactly 6 clocks; there is no early exit.
- Control decode per state:
  - T1 (address): EP, LM.
  - T2 (increment): CP.
  - T3 (memory): CE, LI. The IR captures the instruction on the edge ending T3.
  - T4:
    - LDA/ADD/SUB: EI, LM.
    - OUT: EA, LO.
    - HLT: no control outputs.
    - Any other opcode: none (NOP).
  - T5:
    - LDA: CE, LA.
    - ADD/SUB: CE, LB.
    - Others: none.
  - T6:
    - ADD: EU, LA, with SU = 0.
    - SUB: EU, SU, LA.
    - Others: none.
- SU is asserted only when EU is asserted (T6 of SUB); it is 0 in every other state.
- Halt:
  - On the rising edge that ends T4 with OPCODE == OP_HLT, the halt flag sets and T_STATE stays at T4.
  - While halted: HLT = 1, all control outputs = 0, T_STATE frozen at 6'b001000.
  - Only CLR_N clears the halt flag.
- Invariants in every cycle, including reset:
  - At most one of EP, CE, EI, EA, EU is high (single bus driver).
  - T_STATE is exactly one-hot.
  - No load signal (LM, LI, LA, LB, LO) is high in a state where no driver is high.
- An OPCODE change during T1–T3 has no effect. An OPCODE change during T4–T6 takes effect combinationally; the IR is required to hold OPCODE stable from T4 through T6.

Test Plan:
- Reset: hold CLR_N = 0 for 3 clocks, then release → T_STATE = 000001, EP = LM = 1, all else 0, HLT = 0. After 6 clocks T_STATE = 000001 again.
- ADD: OPCODE = 4'h1 held → T4: EI = LM = 1; T5: CE = LB = 1; T6: EU = LA = 1, SU = 0. The ALU8_1 with A = 8'h35, B = 8'h34 yields bus 8'h69.
- SUB: OPCODE = 4'h2 → T6: EU = SU = LA = 1. With A = 8'h35, B = 8'h34 the bus is 8'h01. SU = 0 in T1–T5.
- LDA then OUT: OPCODE = 4'h0 → T5: CE = LA = 1, T6 all 0. Next instruction OPCODE = 4'hE → T4: EA = LO = 1, T5/T6 all 0.
- HLT: OPCODE = 4'hF → after the T4 edge HLT = 1, T_STATE stays 001000 for 10 further clocks with all controls 0. Pulse CLR_N low → T1, HLT = 0.
- Mid-instruction reset and NOP: drop CLR_N during T5 of SUB → outputs switch to the T1 pattern asynchronously. Then OPCODE = 4'h7 runs 6 clocks with T4–T6 all controls 0. Bus-driver exclusivity is checked every cycle.
